bsg_wormhole_router_output_control: RTL and testbench

Per-output-port arbitration and locking stage of the wormhole router, directly downstream of each input port's header/payload tracking stage. It collects one request bit per input from those stages, chooses a winner round-robin, and forwards the winner's flits to the output. It holds the output for that input until the packet's final flit transfers, and returns a per-input dequeue strobe (`yumi_o`) to the input FIFOs.

---
 rtl/bsg_wormhole_router_output_control.sv | 115 +++++++++++
 tb/tb_bsg_wormhole_router_output_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_wormhole_router_output_control.sv
// Per-output-port arbitration and locking for the wormhole router.
// A round-robin arbiter picks a header among reqs_i while unlocked; the
// winner then owns the output until its release flit transfers.
// Optional simulation checks: define BSG_WORMHOLE_OUTPUT_CONTROL_ASSERT_EN.
module bsg_wormhole_router_output_control #(
  parameter int input_dirs_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [input_dirs_p-1:0] reqs_i,
  input  logic [input_dirs_p-1:0] release_i,
  input  logic [input_dirs_p-1:0] valid_i,
  output logic [input_dirs_p-1:0] yumi_o,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [input_dirs_p-1:0] data_sel_o
);

  localparam int PtrW = (input_dirs_p > 1) ? $clog2(input_dirs_p) : 1;

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e                  r_state, w_state_nxt;
  logic [input_dirs_p-1:0] r_lock_sel, w_lock_sel_nxt;
  logic [PtrW-1:0]         r_rr_ptr, w_rr_ptr_nxt;

  logic [input_dirs_p-1:0] w_rr_sel;
  logic [PtrW-1:0]         w_rr_idx;
  logic                    w_found;
  logic [PtrW:0]           w_sum;
  logic                    w_locked;
  logic                    w_xfer;

  assign w_locked = (r_state == StLocked);

  // Round-robin scan starting at r_rr_ptr, wrapping modulo input_dirs_p.
  always_comb begin
    w_rr_sel = '0;
    w_rr_idx = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    for (int k = 0; k < input_dirs_p; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PtrW+1)'(k);
      if (w_sum >= (PtrW+1)'(input_dirs_p)) begin
        w_sum = w_sum - (PtrW+1)'(input_dirs_p);
      end
      if (!w_found && reqs_i[w_sum[PtrW-1:0]]) begin
        w_found  = 1'b1;
        w_rr_idx = w_sum[PtrW-1:0];
      end
    end
    w_rr_sel[w_rr_idx] = w_found;
  end

  assign data_sel_o = w_locked ? r_lock_sel : w_rr_sel;
  assign valid_o    = w_locked ? |(valid_i & r_lock_sel) : |reqs_i;
  assign w_xfer     = valid_o & ready_i;
  assign yumi_o     = data_sel_o & {input_dirs_p{w_xfer}};

  // Next-state: lock on a non-final header, unlock on the owner's final flit.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_sel_nxt = r_lock_sel;
    w_rr_ptr_nxt   = r_rr_ptr;
    if (w_xfer) begin
      if (!w_locked) begin
        w_rr_ptr_nxt = (w_rr_idx == PtrW'(input_dirs_p - 1)) ? '0 : w_rr_idx + 1'b1;
        if (!(|(release_i & w_rr_sel))) begin
          w_state_nxt    = StLocked;
          w_lock_sel_nxt = w_rr_sel;
        end
      end else if (|(release_i & r_lock_sel)) begin
        w_state_nxt = StUnlocked;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= StUnlocked;
      r_lock_sel <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_sel <= w_lock_sel_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

`ifdef BSG_WORMHOLE_OUTPUT_CONTROL_ASSERT_EN
  logic [10:0] r_stall_cnt;

  // Count consecutive locked cycles where the owner has no flit (saturating).
  always_ff @(posedge clk_i) begin
    if (reset_i || !w_locked || (|(valid_i & r_lock_sel))) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != 11'h7ff) begin
      r_stall_cnt <= r_stall_cnt + 11'd1;
    end
  end

  // Protocol checks sampled outside reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if ($countones(yumi_o) > 1) $error("yumi_o not one-hot: %b", yumi_o);
      if (w_locked && (|(reqs_i & r_lock_sel))) $error("header on locked input mid-packet");
      if (w_locked && !(|(valid_i & r_lock_sel)) && (r_stall_cnt >= 11'd1024)) begin
        $error("locked input stalled for more than 1024 cycles");
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_wormhole_router_output_control.sv
// Self-checking bench for bsg_wormhole_router_output_control: directed
// scenarios plus random traffic, compared against a packet-level model.
module tb_bsg_wormhole_router_output_control;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [N-1:0] reqs_i, release_i, valid_i;
  logic [N-1:0] yumi_o, data_sel_o;
  logic         ready_i, valid_o;

  bsg_wormhole_router_output_control #(.input_dirs_p(N)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .reqs_i     (reqs_i),
    .release_i  (release_i),
    .valid_i    (valid_i),
    .yumi_o     (yumi_o),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_sel_o (data_sel_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which input owns the output (or none), and who is first in line.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_first = 0;

  logic [N-1:0] obs_sel, obs_yumi;
  logic         obs_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Grant: the first requester found walking from m_first around the ring.
  function automatic int pick_winner(input logic [N-1:0] reqs);
    for (int k = 0; k < N; k++) begin
      if (reqs[(m_first + k) % N]) return (m_first + k) % N;
    end
    return -1;
  endfunction

  task automatic cyc();
    int           win;
    logic [N-1:0] e_sel;
    logic         e_valid, xfer;
    @(negedge clk_i);
    win = -1;
    if (m_busy) begin
      e_sel   = N'(1) << m_owner;
      e_valid = valid_i[m_owner];
    end else begin
      win     = pick_winner(reqs_i);
      e_sel   = (win >= 0) ? (N'(1) << win) : '0;
      e_valid = (win >= 0);
    end
    xfer = e_valid && ready_i;
    check("data_sel", 32'(data_sel_o), 32'(e_sel));
    check("valid",    32'(valid_o),    32'(e_valid));
    check("yumi",     32'(yumi_o),     32'(xfer ? e_sel : '0));
    obs_sel   = data_sel_o;
    obs_yumi  = yumi_o;
    obs_valid = valid_o;
    @(posedge clk_i);
    if (reset_i) begin
      m_busy  = 1'b0;
      m_first = 0;
    end else if (xfer) begin
      if (!m_busy) begin
        m_first = (win + 1) % N;
        if (!release_i[win]) begin
          m_busy  = 1'b1;
          m_owner = win;
        end
      end else if (release_i[m_owner]) begin
        m_busy = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] rel, input logic [N-1:0] v,
                       input logic rdy);
    reqs_i = r; release_i = rel; valid_i = v; ready_i = rdy;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    drive('0, '0, '0, 1'b1);
    cyc();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    drive('0, '0, '0, 1'b0);
    cyc();
    cyc();
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive('0, '0, '0, 1'b1);
      cyc();
      check("idle_valid", 32'(obs_valid), 32'd0);
    end

    // Single-flit packet from input 0; then pointer moves to 1.
    drive(4'b0001, 4'b0001, 4'b0001, 1'b1);
    cyc();
    check("single_yumi", 32'(obs_yumi), 32'h1);
    drive(4'b0011, 4'b0011, 4'b0011, 1'b0);
    cyc();
    check("ptr_after_single", 32'(obs_sel), 32'h2);

    // Input 1 wins over 3 at pointer 0 and holds for 4 transfers.
    do_reset();
    drive(4'b1010, 4'b0000, 4'b1010, 1'b1);
    cyc();
    check("hdr_win1", 32'(obs_yumi), 32'h2);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1000, (i == 2) ? 4'b0010 : 4'b0000, 4'b1010, 1'b1);
      cyc();
      check("payload_sel1", 32'(obs_sel), 32'h2);
    end
    drive(4'b1000, 4'b0000, 4'b1000, 1'b1);
    cyc();
    check("next_grant3", 32'(obs_yumi), 32'h8);
    drive(4'b0000, 4'b1000, 4'b1000, 1'b1);
    cyc();

    // Lock on input 2 and stall downstream for 5 cycles.
    drive(4'b0100, 4'b0000, 4'b0100, 1'b1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 4'b0000, 4'b0101, 1'b0);
      cyc();
      check("stall_valid", 32'(obs_valid), 32'd1);
      check("stall_yumi", 32'(obs_yumi), 32'd0);
    end
    drive(4'b0000, 4'b0100, 4'b0100, 1'b1);
    cyc();
    check("resume_yumi", 32'(obs_yumi), 32'h4);

    // All inputs request 1-flit packets: grants 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
      cyc();
      check("rr_order", 32'(obs_yumi), 32'(N'(1) << (i % N)));
    end

    // Reset mid-packet: lock dropped, pointer back to 0.
    drive(4'b0001, 4'b0000, 4'b0001, 1'b1);
    cyc();
    drive(4'b0000, 4'b0000, 4'b0001, 1'b1);
    cyc();
    do_reset();
    drive(4'b0011, 4'b0011, 4'b0011, 1'b1);
    cyc();
    check("post_reset_grant", 32'(obs_yumi), 32'h1);

    // Random traffic; a locked input never re-presents a header.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r, rel, v;
      r   = N'($urandom);
      rel = N'($urandom);
      v   = N'($urandom) | r;
      if (m_busy) r[m_owner] = 1'b0;
      reset_i = ($urandom_range(0, 99) == 0);
      drive(r, rel, v, 1'($urandom_range(0, 3) != 0));
      cyc();
    end
    reset_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
